// File: rtl/aes_ctrl_pkg.sv
// Shared encodings and per-key-width schedule constants for the AES key
// schedule sequencer and its counter block.
package aes_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_ENC  = 2'b10,
        ST_DEC  = 2'b11
    } impl_state_e;

    typedef enum logic [1:0] {
        KW_128 = 2'b00,
        KW_192 = 2'b01,
        KW_256 = 2'b10,
        KW_BAD = 2'b11
    } key_width_e;

    localparam int WORD_W = 32;
    localparam int IDX_W  = 6;

    // Round-key tag travelling one cycle behind the issued word.
    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
        logic             last;
    } rk_tag_t;

    // Key length in 32-bit words.
    function automatic logic [IDX_W-1:0] nk_of(key_width_e w);
        case (w)
            KW_192:  return 6'd6;
            KW_256:  return 6'd8;
            default: return 6'd4;
        endcase
    endfunction

    // Total expanded words, 4*(Nr+1).
    function automatic logic [IDX_W-1:0] words_of(key_width_e w);
        case (w)
            KW_192:  return 6'd52;
            KW_256:  return 6'd60;
            default: return 6'd44;
        endcase
    endfunction

    // Repeat period of the g/h pattern, in 4-word rounds.
    function automatic logic [1:0] period_of(key_width_e w);
        case (w)
            KW_192:  return 2'd3;
            KW_256:  return 2'd2;
            default: return 2'd1;
        endcase
    endfunction

    // Highest rcon index actually consumed by the schedule.
    function automatic logic [3:0] rcon_max_of(key_width_e w);
        case (w)
            KW_192:  return 4'd7;
            KW_256:  return 4'd6;
            default: return 4'd9;
        endcase
    endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// Key request channel: full key plus width code over valid/ready, with an
// error pulse back to the requester for an illegal width.
interface aes_key_sched_ctrl_if #(
    parameter int MAX_NK = 8
);
    logic                  key_valid;
    logic                  key_ready;
    logic [32*MAX_NK-1:0]  key_in;
    logic [1:0]            key_width_in;
    logic                  key_err;

    modport master (
        output key_valid, key_in, key_width_in,
        input  key_ready, key_err
    );

    modport slave (
        input  key_valid, key_in, key_width_in,
        output key_ready, key_err
    );
endinterface

// File: rtl/aes_key_sched_cnt.sv
// Word counter for LOAD/ENC plus the derived datapath controls: position in
// the 4-word round, round within the g/h period, and the rcon index.
module aes_key_sched_cnt
    import aes_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  impl_state_e      state,
    input  key_width_e       width,
    input  logic             abort,
    output logic [IDX_W-1:0] idx,
    output logic             load_last,
    output logic             enc_last,
    output logic [1:0]       cycle_number,
    output logic [1:0]       cycle_round,
    output logic [3:0]       rcon_idx
);

    logic [IDX_W-1:0] nk;
    logic [IDX_W-1:0] total;
    logic [1:0]       period;
    logic [3:0]       rcon_max;
    logic             step;
    logic             g_cycle;

    always_comb begin
        nk       = nk_of(width);
        total    = words_of(width);
        period   = period_of(width);
        rcon_max = rcon_max_of(width);
    end

    assign load_last = (state == ST_LOAD) && (idx == nk - 6'd1);
    assign enc_last  = (state == ST_ENC)  && (idx == total - 6'd1);
    assign step      = ((state == ST_LOAD) || (state == ST_ENC)) && !abort;

    // g-function cycles consume an rcon; the 256-bit h cycles do not.
    assign g_cycle = ((cycle_number == 2'd0) && (cycle_round == 2'd0)) ||
                     ((width == KW_192) && (cycle_round == 2'd1) && (cycle_number == 2'd2));

    always_ff @(posedge clk) begin
        if (rst || !step || enc_last) begin
            idx          <= '0;
            cycle_number <= '0;
            cycle_round  <= '0;
            rcon_idx     <= '0;
        end else begin
            idx <= idx + 6'd1;
            if (state == ST_ENC) begin
                cycle_number <= cycle_number + 2'd1;
                if (cycle_number == 2'd3)
                    cycle_round <= (cycle_round == period - 2'd1) ? 2'd0 : cycle_round + 2'd1;
                // Saturate so the trailing words after the last g cycle keep a valid index.
                if (g_cycle && (rcon_idx != rcon_max))
                    rcon_idx <= rcon_idx + 4'd1;
            end
        end
    end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES key-expansion sequencer: takes a key, streams it word by word into the
// datapath, drives the schedule controls and tags the returned round keys.
module aes_key_sched_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int MAX_NK = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    aes_key_sched_ctrl_if.slave      key_if,
    input  logic                     abort,
    output logic [1:0]               key_width,
    output logic [WORD_W-1:0]        initial_key_word,
    output logic [1:0]               implement_state,
    output logic                     jump_to_dec,
    output logic [1:0]               cycle_number,
    output logic [1:0]               cycle_round,
    output logic [3:0]               key_expand_round_number,
    input  logic [WORD_W-1:0]        rk_word_in,
    output logic                     rk_valid,
    output logic [WORD_W-1:0]        rk_word,
    output logic [IDX_W-1:0]         rk_index,
    output logic                     rk_last
);

    localparam int KEY_W = WORD_W * MAX_NK;

    impl_state_e      state;
    key_width_e       width_q;
    logic [KEY_W-1:0] key_q;
    logic             err_q;
    rk_tag_t          tag;

    logic [IDX_W-1:0] idx;
    logic             load_last;
    logic             enc_last;
    logic             step;

    assign step = ((state == ST_LOAD) || (state == ST_ENC)) && !abort;

    aes_key_sched_cnt u_cnt (
        .clk          (clk),
        .rst          (rst),
        .state        (state),
        .width        (width_q),
        .abort        (abort),
        .idx          (idx),
        .load_last    (load_last),
        .enc_last     (enc_last),
        .cycle_number (cycle_number),
        .cycle_round  (cycle_round),
        .rcon_idx     (key_expand_round_number)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            width_q <= KW_128;
            key_q   <= '0;
            err_q   <= 1'b0;
            tag     <= '0;
        end else begin
            err_q    <= 1'b0;
            tag.vld  <= step;
            tag.idx  <= step ? idx : '0;
            tag.last <= step && enc_last;
            unique case (state)
                ST_IDLE: begin
                    if (key_if.key_valid) begin
                        if (key_if.key_width_in == KW_BAD) begin
                            err_q <= 1'b1;
                        end else begin
                            key_q   <= key_if.key_in;
                            width_q <= key_width_e'(key_if.key_width_in);
                            state   <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    // Shift the shadow so the next key word is always on top;
                    // wipe it once the datapath holds the key.
                    if (abort || load_last) begin
                        key_q <= '0;
                        state <= abort ? ST_IDLE : ST_ENC;
                    end else begin
                        key_q <= key_q << WORD_W;
                    end
                end
                ST_ENC: begin
                    if (abort || enc_last)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign key_if.key_ready = (state == ST_IDLE);
    assign key_if.key_err   = err_q;
    assign key_width        = width_q;
    assign implement_state  = state;
    assign jump_to_dec      = 1'b0;
    assign initial_key_word = (state == ST_LOAD) ? key_q[KEY_W-1 -: WORD_W] : '0;
    assign rk_valid         = tag.vld;
    assign rk_index         = tag.idx;
    assign rk_last          = tag.last;
    assign rk_word          = tag.vld ? rk_word_in : '0;

endmodule
